// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It decides,
// once per cycle, whether the front end advances, stalls or is flushed:
//   * a taken branch in EX flushes IF/ID and bubbles ID/EX,
//   * a multi-cycle ALU op keeps EX busy, so the front end freezes and ID/EX
//     is fed bubbles for the remaining occupancy cycles,
//   * a load in EX whose destination feeds the ID instruction (load-use)
//     stalls the front end for one cycle and inserts a bubble.
// Two saturating counters record stall cycles and taken-branch flush cycles.
//
// Parameters
//   MC_CYCLES  total EX occupancy of a multi-cycle op, legal range 2..15
//   CNT_W      width of the performance counters
//
// Ports
//   CLOCK           rising-edge clock
//   RESET_N         asynchronous active-low reset
//   ID_RSAddr       rs field of the instruction in ID
//   ID_RTAddr       rt field of the instruction in ID
//   ID_UsesRT       ID instruction reads rt as a source
//   ID_MultiCycle   ID instruction is a multi-cycle ALU op
//   EX_Mem2RegSEL   writeback select of the EX instruction (2'b01 = load)
//   EX_RegWriteEN   EX instruction writes the register file
//   EX_RTAddr       destination (rt) of the EX instruction
//   EX_BranchTaken  branch in EX resolved taken this cycle
//   PCWriteEN       PC update enable
//   IFIDWriteEN     IF/ID register load enable
//   IFIDFlush       clear IF/ID to NOP at the next edge
//   IDEXBubble      force ID/EX control to NOP at the next edge
//   Busy            registered: controller is waiting on a multi-cycle op
//   StallCount      saturating count of stall cycles
//   FlushCount      saturating count of taken-branch flush cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [4:0]       ID_RSAddr,
    input  logic [4:0]       ID_RTAddr,
    input  logic             ID_UsesRT,
    input  logic             ID_MultiCycle,
    input  logic [1:0]       EX_Mem2RegSEL,
    input  logic             EX_RegWriteEN,
    input  logic [4:0]       EX_RTAddr,
    input  logic             EX_BranchTaken,
    output logic             PCWriteEN,
    output logic             IFIDWriteEN,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MCWAIT = 1'b1
    } state_e;

    // The issue cycle itself is the first EX cycle, so the wait counter is
    // loaded with the number of remaining cycles.
    localparam logic [3:0]       MC_LOAD  = 4'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       mc_cnt_q, mc_cnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             load_use;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;

    // Load-use hazard: the EX instruction is a load writing a non-zero
    // register that the ID instruction reads. r0 is hard-wired to zero, so a
    // load "into" r0 never creates a dependency.
    always_comb begin
        load_use = EX_RegWriteEN
                 & (EX_Mem2RegSEL == 2'b01)
                 & (EX_RTAddr != 5'd0)
                 & ((EX_RTAddr == ID_RSAddr)
                    | (ID_UsesRT & (EX_RTAddr == ID_RTAddr)));
    end

    // Next-state and raw control decode. Priority: taken branch, then the
    // multi-cycle wait, then load-use, then normal flow. A branch kills the
    // younger instructions, so it also aborts any pending multi-cycle wait.
    // A multi-cycle op only issues from the normal-flow branch, so it can
    // never issue while a load-use hazard or a taken branch is present.
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (EX_BranchTaken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            mc_cnt_d    = 4'd0;
        end else if (state_q == ST_MCWAIT) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            // The "<= 1" guard also recovers from a zero count, which can
            // only arise from an out-of-range MC_CYCLES.
            if (mc_cnt_q <= 4'd1) begin
                state_d  = ST_RUN;
                mc_cnt_d = 4'd0;
            end else begin
                mc_cnt_d = mc_cnt_q - 4'd1;
            end
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (ID_MultiCycle) begin
            state_d  = ST_MCWAIT;
            mc_cnt_d = MC_LOAD;
        end
    end

    // Busy mirrors the registered state, so it is computed from the next
    // state and captured alongside it.
    always_comb begin
        busy_d = (state_d == ST_MCWAIT);
    end

    // Performance counters. Bubbles caused by a branch are flushes, not
    // stalls, so they are excluded from the stall count. Both counters stop
    // at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (idex_bubble && !EX_BranchTaken && (stall_cnt_q != CNT_FULL)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end

        if (EX_BranchTaken && (flush_cnt_q != CNT_FULL)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State registers. Reset drops any pending multi-cycle wait so the
    // pipeline restarts cleanly in RUN.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= 4'd0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While reset is held the front end is frozen and both pipeline
    // registers are forced to NOP, independent of the clock and of the
    // hazard inputs.
    always_comb begin
        if (!RESET_N) begin
            PCWriteEN   = 1'b0;
            IFIDWriteEN = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
        end else begin
            PCWriteEN   = pc_we;
            IFIDWriteEN = ifid_we;
            IFIDFlush   = ifid_flush;
            IDEXBubble  = idex_bubble;
        end
    end

    assign Busy       = busy_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed testbench for pipe_hazard_ctrl. The DUT uses MC_CYCLES=4 and a
// 4-bit counter width so that counter saturation is reachable in a few cycles.
// Inputs change 1 time unit after the rising edge; outputs are checked in the
// middle of the cycle, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MC = 4;
    localparam int CW = 4;

    logic          CLOCK;
    logic          RESET_N;
    logic [4:0]    ID_RSAddr;
    logic [4:0]    ID_RTAddr;
    logic          ID_UsesRT;
    logic          ID_MultiCycle;
    logic [1:0]    EX_Mem2RegSEL;
    logic          EX_RegWriteEN;
    logic [4:0]    EX_RTAddr;
    logic          EX_BranchTaken;
    logic          PCWriteEN;
    logic          IFIDWriteEN;
    logic          IFIDFlush;
    logic          IDEXBubble;
    logic          Busy;
    logic [CW-1:0] StallCount;
    logic [CW-1:0] FlushCount;

    int compareCount  = 0;
    int mismatchCount = 0;

    pipe_hazard_ctrl #(
        .MC_CYCLES (MC),
        .CNT_W     (CW)
    ) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .ID_RSAddr      (ID_RSAddr),
        .ID_RTAddr      (ID_RTAddr),
        .ID_UsesRT      (ID_UsesRT),
        .ID_MultiCycle  (ID_MultiCycle),
        .EX_Mem2RegSEL  (EX_Mem2RegSEL),
        .EX_RegWriteEN  (EX_RegWriteEN),
        .EX_RTAddr      (EX_RTAddr),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWriteEN      (PCWriteEN),
        .IFIDWriteEN    (IFIDWriteEN),
        .IFIDFlush      (IFIDFlush),
        .IDEXBubble     (IDEXBubble),
        .Busy           (Busy),
        .StallCount     (StallCount),
        .FlushCount     (FlushCount)
    );

    // 10-unit clock period.
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Checks the four combinational front-end controls at once.
    task automatic checkCtrl(input string tag, input int pc, input int ifid,
                             input int flush, input int bubble);
        checkOutput({tag, ".PCWriteEN"},   int'(PCWriteEN),   pc);
        checkOutput({tag, ".IFIDWriteEN"}, int'(IFIDWriteEN), ifid);
        checkOutput({tag, ".IFIDFlush"},   int'(IFIDFlush),   flush);
        checkOutput({tag, ".IDEXBubble"},  int'(IDEXBubble),  bubble);
    endtask

    // Drives one full set of hazard inputs.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic multi,
                                 input logic [1:0] memSel, input logic regWr,
                                 input logic [4:0] exRt, input logic branch);
        ID_RSAddr      = rs;
        ID_RTAddr      = rt;
        ID_UsesRT      = usesRt;
        ID_MultiCycle  = multi;
        EX_Mem2RegSEL  = memSel;
        EX_RegWriteEN  = regWr;
        EX_RTAddr      = exRt;
        EX_BranchTaken = branch;
    endtask

    task automatic idle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 2'b00, 1'b0, 5'd9, 1'b0);
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulseReset();
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
    endtask

    // Load in EX writing r5, ID reading r5 through rs.
    task automatic loadUseRs();
        applyStimulus(5'd5, 5'd2, 1'b0, 1'b0, 2'b01, 1'b1, 5'd5, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0;
        applyStimulus(5'd5, 5'd5, 1'b1, 1'b1, 2'b01, 1'b1, 5'd5, 1'b1);
        #3;

        // Reset held with every hazard input active: outputs forced.
        checkCtrl("reset_hold", 0, 0, 1, 1);
        checkOutput("reset_busy",  int'(Busy), 0);
        checkOutput("reset_stall", int'(StallCount), 0);
        checkOutput("reset_flush", int'(FlushCount), 0);

        tick();
        idle();
        RESET_N = 1'b1;
        #2;
        checkCtrl("run_idle", 1, 1, 0, 0);

        // r0 exemption: a load into r0 never stalls.
        tick();
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd0, 1'b0);
        #2;
        checkCtrl("r0_load", 1, 1, 0, 0);
        tick();
        idle();
        checkOutput("r0_stallcnt", int'(StallCount), 0);

        // Load-use through rs: one stall cycle.
        loadUseRs();
        #2;
        checkCtrl("lu_rs", 0, 0, 0, 1);
        tick();
        idle();
        #2;
        checkCtrl("lu_rs_after", 1, 1, 0, 0);
        checkOutput("lu_rs_stallcnt", int'(StallCount), 1);

        // Load-use through rt when rt is a source.
        tick();
        applyStimulus(5'd3, 5'd7, 1'b1, 1'b0, 2'b01, 1'b1, 5'd7, 1'b0);
        #2;
        checkCtrl("lu_rt", 0, 0, 0, 1);
        tick();
        checkOutput("lu_rt_stallcnt", int'(StallCount), 2);

        // rt match but rt not read: no hazard.
        applyStimulus(5'd3, 5'd7, 1'b0, 1'b0, 2'b01, 1'b1, 5'd7, 1'b0);
        #2;
        checkCtrl("rt_unused", 1, 1, 0, 0);

        // Matching register but EX is not a load: no hazard.
        tick();
        applyStimulus(5'd5, 5'd2, 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 1'b0);
        #2;
        checkCtrl("non_load", 1, 1, 0, 0);
        tick();
        checkOutput("non_load_stallcnt", int'(StallCount), 2);

        // Multi-cycle op: issue cycle then exactly MC-1 busy bubble cycles.
        pulseReset();
        idle();
        ID_MultiCycle = 1'b1;
        #1;
        checkCtrl("mc_issue", 1, 1, 0, 0);
        checkOutput("mc_issue_busy", int'(Busy), 0);
        tick();
        idle();
        for (int i = 0; i < MC - 1; i++) begin
            #2;
            checkCtrl($sformatf("mc_wait%0d", i), 0, 0, 0, 1);
            checkOutput($sformatf("mc_wait%0d_busy", i), int'(Busy), 1);
            tick();
        end
        #2;
        checkCtrl("mc_done", 1, 1, 0, 0);
        checkOutput("mc_done_busy", int'(Busy), 0);
        checkOutput("mc_stallcnt", int'(StallCount), 3);

        // Branch taken in the 2nd wait cycle aborts the wait.
        tick();
        ID_MultiCycle = 1'b1;
        tick();
        idle();
        checkOutput("mcbr_wait1_busy", int'(Busy), 1);
        tick();
        EX_BranchTaken = 1'b1;
        #2;
        checkCtrl("mcbr_branch", 1, 1, 1, 1);
        tick();
        idle();
        #2;
        checkOutput("mcbr_busy", int'(Busy), 0);
        checkCtrl("mcbr_after", 1, 1, 0, 0);
        checkOutput("mcbr_flushcnt", int'(FlushCount), 1);
        checkOutput("mcbr_stallcnt", int'(StallCount), 4);
        tick();
        checkOutput("mcbr_stays_run", int'(Busy), 0);

        // Load-use and taken branch together: the branch wins.
        loadUseRs();
        EX_BranchTaken = 1'b1;
        #2;
        checkCtrl("lu_branch", 1, 1, 1, 1);
        tick();
        idle();
        checkOutput("lu_branch_stallcnt", int'(StallCount), 4);
        checkOutput("lu_branch_flushcnt", int'(FlushCount), 2);

        // A multi-cycle op waits while load-use is present.
        loadUseRs();
        ID_MultiCycle = 1'b1;
        #2;
        checkCtrl("mc_blocked", 0, 0, 0, 1);
        tick();
        checkOutput("mc_blocked_busy", int'(Busy), 0);
        checkOutput("mc_blocked_stallcnt", int'(StallCount), 5);
        idle();
        ID_MultiCycle = 1'b1;
        tick();
        idle();
        checkOutput("mc_unblocked_busy", int'(Busy), 1);
        tick();
        checkOutput("mc_wait_stallcnt", int'(StallCount), 6);

        // Reset mid-wait: everything returns to reset values without an edge.
        RESET_N = 1'b0;
        #1;
        checkCtrl("rst_midwait", 0, 0, 1, 1);
        checkOutput("rst_midwait_busy",  int'(Busy), 0);
        checkOutput("rst_midwait_stall", int'(StallCount), 0);
        checkOutput("rst_midwait_flush", int'(FlushCount), 0);
        #1;
        RESET_N = 1'b1;
        #1;
        checkCtrl("rst_release", 1, 1, 0, 0);
        tick();
        #2;
        checkCtrl("rst_no_residual", 1, 1, 0, 0);
        checkOutput("rst_no_residual_busy", int'(Busy), 0);

        // Saturation: sustained load-use drives StallCount to all-ones.
        tick();
        loadUseRs();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("stall_sat", int'(StallCount), 15);
        tick();
        checkOutput("stall_sat_hold", int'(StallCount), 15);

        // Saturation of FlushCount under repeated taken branches.
        idle();
        EX_BranchTaken = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        checkOutput("flush_sat", int'(FlushCount), 15);
        checkOutput("flush_sat_stall", int'(StallCount), 15);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_CYCLES, default 4, meaning total EX occupancy in cycles of a multi-cycle ALU op; legal range 2..15.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 SHALL have port CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ID_RSAddr  input  5  rs field of the instruction in ID.
REQ-006 SHALL have port ID_RTAddr  input  5  rt field of the instruction in ID.
REQ-007 SHALL have port ID_UsesRT  input  1  ID instruction reads rt as a source.
REQ-008 SHALL have port ID_MultiCycle  input  1  ID instruction is a multi-cycle ALU op.
REQ-009 SHALL have port EX_Mem2RegSEL  input  2  writeback select of the EX instruction; 2'b01 = memory load.
REQ-010 SHALL have port EX_RegWriteEN  input  1  EX instruction writes the register file.
REQ-011 SHALL have port EX_RTAddr  input  5  destination (rt) of the EX instruction.
REQ-012 SHALL have port EX_BranchTaken  input  1  beq/bne in EX resolved taken this cycle.
REQ-013 SHALL have port PCWriteEN  output  1  PC update enable.
REQ-014 SHALL have port IFIDWriteEN  output  1  IF/ID register load enable.
REQ-015 SHALL have port IFIDFlush  output  1  clear IF/ID to NOP at the next edge.
REQ-016 SHALL have port IDEXBubble  output  1  force all ID/EX control inputs to 0 (NOP) at the next edge.
REQ-017 SHALL have port Busy  output  1  state is MCWAIT.
REQ-018 SHALL have port StallCount  output  CNT_W  count of stall cycles.
REQ-019 SHALL have port FlushCount  output  CNT_W  count of taken-branch flush cycles.

Function
REQ-020 SHALL use a two-state FSM, RUN and MCWAIT, plus a 4-bit down-counter MCCnt.
REQ-021 SHALL define the load-use hazard LU = EX_RegWriteEN & (EX_Mem2RegSEL==2'b01) & (EX_RTAddr!=0) & ((EX_RTAddr==ID_RSAddr) | (ID_UsesRT & EX_RTAddr==ID_RTAddr)).
REQ-022 SHALL compute the control outputs combinationally from state and inputs, in priority order: branch, then MCWAIT, then LU, then normal.
REQ-023 SHALL, when EX_BranchTaken=1 in any state, drive PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=1, IDEXBubble=1, and set next state to RUN (aborting MCWAIT).
REQ-024 SHALL, in MCWAIT with no branch, drive PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=0, IDEXBubble=1, and decrement MCCnt each cycle.
REQ-025 SHALL, in MCWAIT with MCCnt==1, return to RUN at the next edge, so exactly MC_CYCLES-1 bubble cycles follow the issue cycle.
REQ-026 SHALL, in RUN with LU=1 and no branch, drive PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=0, IDEXBubble=1, and remain in RUN.
REQ-027 SHALL, in RUN with no branch and no LU, drive PCWriteEN=1, IFIDWriteEN=1, IFIDFlush=0, IDEXBubble=0.
REQ-028 SHALL, in RUN with no branch, no LU and ID_MultiCycle=1 (issue cycle), enter MCWAIT with MCCnt=MC_CYCLES-1.
REQ-029 SHALL never issue a multi-cycle op while LU=1 or EX_BranchTaken=1; the issue waits until the hazard clears.
REQ-030 SHALL make Busy a registered function of state: 1 exactly when state is MCWAIT.
REQ-031 SHALL increment StallCount on every edge where IDEXBubble=1 and EX_BranchTaken=0 (LU and MCWAIT cycles).
REQ-032 SHALL increment FlushCount on every edge where EX_BranchTaken=1.
REQ-033 SHALL make both counters saturate at all-ones and never wrap.

Reset
REQ-034 SHALL, on RESET_N low, immediately and independently of CLOCK, set state=RUN, MCCnt=0, StallCount=0, FlushCount=0, and Busy=0.
REQ-035 SHALL, while RESET_N is low, hold PCWriteEN=0, IFIDWriteEN=0, IFIDFlush=1, IDEXBubble=1 regardless of inputs.
REQ-036 SHALL, on reset assertion during MCWAIT, abandon the remaining wait; after release the block starts in RUN with no residual stall.
REQ-037 SHALL apply normal RUN outputs from the first edge after RESET_N deasserts.

Verification
REQ-038 SHALL cover load-use: EX load with EX_RTAddr=5, ID_RSAddr=5 for one cycle -> one cycle of PCWriteEN=0 and IDEXBubble=1, StallCount=1.
REQ-039 SHALL cover the r0 exemption: same as REQ-038 but EX_RTAddr=0 -> no stall, StallCount=0.
REQ-040 SHALL cover the multi-cycle op: ID_MultiCycle=1 with MC_CYCLES=4 -> issue cycle, then exactly 3 cycles with Busy=1 and bubbles, then RUN; StallCount=3.
REQ-041 SHALL cover branch during MCWAIT: EX_BranchTaken=1 in the 2nd wait cycle -> IFIDFlush=1, state RUN next cycle, FlushCount=1.
REQ-042 SHALL cover simultaneous events: LU=1 and EX_BranchTaken=1 in the same cycle -> flush outputs (PCWriteEN=1, IFIDFlush=1), StallCount unchanged.
REQ-043 SHALL cover saturation and reset: preload counters near all-ones, then sustain LU -> counter holds at all-ones; assert RESET_N=0 mid-MCWAIT -> all outputs at reset values with no clock edge.
